// File: rtl/ext_pkg.sv
// Shared definitions for the pipelined extension unit.
// Mode encodings, mode width and byte-offset width helper.
package ext_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      EXT_ZERO = 3'd0,
      EXT_SIGN = 3'd1,
      EXT_LUI  = 3'd2,
      EXT_LB   = 3'd3,
      EXT_LBU  = 3'd4,
      EXT_LH   = 3'd5,
      EXT_LHU  = 3'd6,
      EXT_LW   = 3'd7
   } ext_mode_e;

   function automatic int off_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational immediate / load-data extender.
// Little-endian lane select, misaligned halves and words flag an error.
module ext_core
   import ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int OFF_W  = 2
) (
   input  logic [MODE_W-1:0] i_mode,
   input  logic [IMM_W-1:0]  i_imm,
   input  logic [DATA_W-1:0] i_word,
   input  logic [OFF_W-1:0]  i_off,
   output logic [DATA_W-1:0] o_data,
   output logic              o_err
);

   localparam int NB = DATA_W / 8;

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = '0;
      w_half = '0;
      for (int i = 0; i < NB; i++)
         if (i_off == OFF_W'(i))
            w_byte = i_word[8*i +: 8];
      // the top lane is odd, so it never yields a legal half
      for (int i = 0; i < NB - 1; i++)
         if (i_off == OFF_W'(i))
            w_half = i_word[8*i +: 16];
   end

   always_comb begin
      o_data = '0;
      o_err  = 1'b0;
      unique case (i_mode)
         EXT_ZERO: o_data = {{(DATA_W-IMM_W){1'b0}}, i_imm};
         EXT_SIGN: o_data = {{(DATA_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
         EXT_LUI:  o_data = {i_imm, {(DATA_W-IMM_W){1'b0}}};
         EXT_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
         EXT_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
         EXT_LH, EXT_LHU: begin
            if (i_off[0])
               o_err = 1'b1;
            else if (i_mode == EXT_LH)
               o_data = {{(DATA_W-16){w_half[15]}}, w_half};
            else
               o_data = {{(DATA_W-16){1'b0}}, w_half};
         end
         EXT_LW: begin
            if (i_off != '0)
               o_err = 1'b1;
            else
               o_data = i_word;
         end
      endcase
   end

endmodule

// File: rtl/ext_unit.sv
// Pipelined extension unit: ext_core on the input side feeding
// a main + skid result buffer with valid/ready on both ends.
module ext_unit
   import ext_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int IMM_W   = 16,
   parameter int TAG_W   = 5,
   localparam int OFF_W  = off_w(DATA_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MODE_W-1:0] in_mode,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [DATA_W-1:0] in_word,
   input  logic [OFF_W-1:0]  in_off,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic [TAG_W-1:0]  out_tag
);

   logic [DATA_W-1:0] w_data;
   logic              w_err;
   logic              w_acc;
   logic              w_pop;

   logic              r_rdy;
   logic              r_main_v;
   logic [DATA_W-1:0] r_main_data;
   logic              r_main_err;
   logic [TAG_W-1:0]  r_main_tag;
   logic              r_skid_v;
   logic [DATA_W-1:0] r_skid_data;
   logic              r_skid_err;
   logic [TAG_W-1:0]  r_skid_tag;

   ext_core #(
      .DATA_W (DATA_W),
      .IMM_W  (IMM_W),
      .OFF_W  (OFF_W)
   ) u_core (
      .i_mode (in_mode),
      .i_imm  (in_imm),
      .i_word (in_word),
      .i_off  (in_off),
      .o_data (w_data),
      .o_err  (w_err)
   );

   assign w_acc = in_valid && r_rdy;
   assign w_pop = !r_main_v || out_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rdy       <= 1'b1;
         r_main_v    <= 1'b0;
         r_main_data <= '0;
         r_main_err  <= 1'b0;
         r_main_tag  <= '0;
         r_skid_v    <= 1'b0;
         r_skid_data <= '0;
         r_skid_err  <= 1'b0;
         r_skid_tag  <= '0;
      end else if (w_pop) begin
         // skid full implies in_ready low, so nothing arrives here
         if (r_skid_v) begin
            r_main_v    <= 1'b1;
            r_main_data <= r_skid_data;
            r_main_err  <= r_skid_err;
            r_main_tag  <= r_skid_tag;
            r_skid_v    <= 1'b0;
            r_rdy       <= 1'b1;
         end else begin
            r_main_v <= w_acc;
            if (w_acc) begin
               r_main_data <= w_data;
               r_main_err  <= w_err;
               r_main_tag  <= in_tag;
            end
         end
      end else if (w_acc) begin
         r_skid_v    <= 1'b1;
         r_skid_data <= w_data;
         r_skid_err  <= w_err;
         r_skid_tag  <= in_tag;
         r_rdy       <= 1'b0;
      end
   end

   assign in_ready  = r_rdy;
   assign out_valid = r_main_v;
   assign out_data  = r_main_data;
   assign out_err   = r_main_err;
   assign out_tag   = r_main_tag;

endmodule

// File: tb/tb_ext_unit.sv
// Scoreboard bench for ext_unit: driver pushes expected results,
// a negedge monitor pops and compares on every delivery.
module tb_ext_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_mode;
   logic [15:0] in_imm;
   logic [31:0] in_word;
   logic [1:0]  in_off;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_err;
   logic [4:0]  out_tag;

   typedef struct packed {
      logic [31:0] d;
      logic        e;
      logic [4:0]  t;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_deliv = 0;

   localparam logic [31:0] WD = 32'h12F45678;

   always #5 clk = ~clk;

   ext_unit #(.DATA_W(32), .IMM_W(16), .TAG_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_imm    (in_imm),
      .in_word   (in_word),
      .in_off    (in_off),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .out_tag   (out_tag)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // call at a negedge; returns at the negedge after the accept edge
   task automatic send(input logic [2:0] m, input logic [15:0] imm,
                       input logic [31:0] w, input logic [1:0] off,
                       input logic [4:0] tag, input logic [31:0] ed,
                       input logic ee);
      int n = 0;
      in_valid = 1'b1;
      in_mode  = m;
      in_imm   = imm;
      in_word  = w;
      in_off   = off;
      in_tag   = tag;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: tag %0d not accepted", tag);
      end else begin
         exp_q.push_back('{d: ed, e: ee, t: tag});
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_mode  = 3'bx;
      in_word  = 'x;
   endtask

   // monitor
   initial begin
      exp_t e;
      exp_t held;
      logic stalled = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!reset || !out_valid) begin
            stalled = 1'b0;
         end else if (out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: tag %0d data %h",
                        out_tag, out_data);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", out_data, e.d);
               chk("out_err", {31'd0, out_err}, {31'd0, e.e});
               chk("out_tag", {27'd0, out_tag}, {27'd0, e.t});
            end
            n_deliv++;
            stalled = 1'b0;
         end else begin
            if (stalled)
               chk("stall_hold", {out_data[25:0], out_err, out_tag},
                   {held.d[25:0], held.e, held.t});
            held    = '{d: out_data, e: out_err, t: out_tag};
            stalled = 1'b1;
         end
      end
   end

   initial begin
      int base;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_mode   = '0;
      in_imm    = '0;
      in_word   = '0;
      in_off    = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_data", out_data, 32'd0);

      send(3'd1, 16'h8001, '0, 2'd3, 5'd1, 32'hFFFF8001, 1'b0);
      chk("latency_1", {31'd0, out_valid}, 32'd1);
      send(3'd0, 16'h8001, '0, 2'd1, 5'd2, 32'h00008001, 1'b0);
      send(3'd2, 16'h8001, '0, 2'd2, 5'd3, 32'h80010000, 1'b0);
      send(3'd3, '0, WD, 2'd2, 5'd4, 32'hFFFFFFF4, 1'b0);
      send(3'd4, '0, WD, 2'd2, 5'd5, 32'h000000F4, 1'b0);
      send(3'd6, '0, WD, 2'd2, 5'd6, 32'h000012F4, 1'b0);
      send(3'd5, '0, WD, 2'd0, 5'd8, 32'h00005678, 1'b0);
      send(3'd5, '0, WD, 2'd1, 5'd7, 32'h00000000, 1'b1);
      send(3'd7, '0, WD, 2'd0, 5'd9, WD, 1'b0);
      send(3'd7, '0, WD, 2'd2, 5'd10, 32'h0, 1'b1);
      send(3'd3, '0, WD, 2'd3, 5'd11, 32'h00000012, 1'b0);
      send(3'd6, '0, WD, 2'd3, 5'd12, 32'h0, 1'b1);
      send(3'd5, '0, 32'h8000_0000, 2'd2, 5'd13, 32'hFFFF8000, 1'b0);
      repeat (3) @(negedge clk);

      // backpressure
      out_ready = 1'b0;
      send(3'd0, 16'h0001, '0, 2'd0, 5'd1, 32'h1, 1'b0);
      send(3'd0, 16'h0002, '0, 2'd0, 5'd2, 32'h2, 1'b0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      fork
         begin
            send(3'd0, 16'h0003, '0, 2'd0, 5'd3, 32'h3, 1'b0);
            send(3'd0, 16'h0004, '0, 2'd0, 5'd4, 32'h4, 1'b0);
         end
         begin
            repeat (4) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      repeat (4) @(negedge clk);

      // full throughput
      base = n_deliv;
      for (int i = 0; i < 8; i++) begin
         chk("tp_in_ready", {31'd0, in_ready}, 32'd1);
         send(3'd4, '0, 32'hA1B2C3D4, 2'(i), 5'(16 + i),
              {24'd0, 8'(32'hA1B2C3D4 >> (8 * (i % 4)))}, 1'b0);
         chk("tp_out_valid", {31'd0, out_valid}, 32'd1);
      end
      repeat (3) @(negedge clk);
      chk("tp_count", 32'(n_deliv - base), 32'd8);

      // reset with two entries held
      out_ready = 1'b0;
      send(3'd0, 16'h0009, '0, 2'd0, 5'd9, 32'h9, 1'b0);
      send(3'd0, 16'h000A, '0, 2'd0, 5'd10, 32'hA, 1'b0);
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst2_out_data", out_data, 32'd0);
      chk("rst2_out_tag", {27'd0, out_tag}, 32'd0);
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      send(3'd1, 16'h7FFF, '0, 2'd0, 5'd30, 32'h00007FFF, 1'b0);
      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
